// File: rtl/serial_add_sub.sv
// Purpose : multi-cycle two's-complement adder/subtractor, LSB-first, DIGIT bits per clock,
//           with carry-out, carry-into-MSB, signed overflow and optional saturation.
// Latency : WIDTH/DIGIT cycles from accepted start to the done pulse; one op per N+1 cycles.
// Backpressure: none; start is only sampled while not busy, and ignored during a computation.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             request; accepted in IDLE or DONE
//   a, b              WIDTH-bit operands, captured on the accepted start edge
//   sub               0: a+b, 1: a-b (as a + ~b + 1), captured with start
//   sat               clamp the result on signed overflow, captured with start
//   busy              high while a computation is in flight
//   done              one-cycle pulse when the result registers update
//   s                 result (raw modular sum, or clamped when sat and ovf)
//   c_msb, c_msb1     carry out of bit WIDTH-1 / carry into bit WIDTH-1 (raw)
//   ovf               signed overflow, c_msb ^ c_msb1
//
// WIDTH must be >= 2 and an integer multiple of DIGIT.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_msb,
    output logic             c_msb1,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  res_sh;
    logic              carry;
    logic              sat_q;
    logic [CW-1:0]     cnt;

    logic [DIGIT:0]    dsum;
    logic              c_top;
    logic              raw_ovf;
    logic [WIDTH-1:0]  res_next;
    logic [WIDTH-1:0]  sat_val;

    always_comb begin
        dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        // Sum bit = a ^ b ^ carry_in, so the carry into the digit's top bit falls out
        // of the top sum bit without a second, narrower adder.
        c_top    = dsum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
        raw_ovf  = dsum[DIGIT] ^ c_top;
        // New digit enters from the MSB side; after N steps the first digit sits at bit 0.
        res_next = (res_sh >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        // Positive overflow always has c_msb=0, negative overflow c_msb=1.
        sat_val  = {dsum[DIGIT], {(WIDTH-1){~dsum[DIGIT]}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            sat_q  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            s      <= '0;
            c_msb  <= 1'b0;
            c_msb1 <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        sat_q <= sat;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_next;
                    carry  <= dsum[DIGIT];
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // All result registers change together on this edge only.
                        s      <= (sat_q && raw_ovf) ? sat_val : res_next;
                        c_msb  <= dsum[DIGIT];
                        c_msb1 <= c_top;
                        ovf    <= raw_ovf;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
